// File: rtl/dp_ram_arb_pkg.sv
// Shared constants and helpers for the dual-port RAM arbiter.
// Imported by the arbiter, its interface and the rr_arbiter core.
package dp_ram_arb_pkg;

  localparam int NUM_REQ_DEF    = 4;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 3;

  function automatic int rr_next(input int i, input int n);
    return (i + 1) % n;
  endfunction

endpackage

// File: rtl/dp_ram_arb_if.sv
// RAM-side bus: async read port plus sync write port.
// The arbiter is master, the RAM macro is slave.
interface dp_ram_if
  import dp_ram_arb_pkg::*;
#(
  parameter int DW = DATA_WIDTH_DEF,
  parameter int AW = ADDR_WIDTH_DEF
) ();

  logic          ram_rd_en;
  logic [AW-1:0] ram_rd_addr;
  logic [DW-1:0] ram_data_out;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr;
  logic [DW-1:0] ram_data_in;

  modport master (
    output ram_rd_en,
    output ram_rd_addr,
    input  ram_data_out,
    output ram_wr_en,
    output ram_wr_addr,
    output ram_data_in
  );

  modport slave (
    input  ram_rd_en,
    input  ram_rd_addr,
    output ram_data_out,
    input  ram_wr_en,
    input  ram_wr_addr,
    input  ram_data_in
  );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer
// advances past the winner on the following edge.
module rr_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int N = NUM_REQ_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    logic found;
    int   idx;
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found    = 1'b1;
        gnt[idx] = 1'b1;
        ptr_d    = PW'(rr_next(idx, N));
      end
    end
    // Reset masks the grant so nothing reaches the RAM.
    if (rst) begin
      gnt   = '0;
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Shares one dual-port RAM among NUM_REQ requesters; read and
// write ports are arbitrated independently, read latency 1.
module dp_ram_arbiter
  import dp_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_REQ-1:0]            rd_gnt,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic [NUM_REQ-1:0]            rd_data_valid,
  input  logic [NUM_REQ-1:0]            wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wr_data,
  output logic [NUM_REQ-1:0]            wr_gnt,
  dp_ram_if.master                      ram
);

  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [DW-1:0]      rd_data_q;
  logic [DW-1:0]      rd_data_d;
  logic [NUM_REQ-1:0] rd_vld_q;
  logic [NUM_REQ-1:0] rd_vld_d;
  logic [AW-1:0]      rd_mux;
  logic [AW-1:0]      wa_mux;
  logic [DW-1:0]      wd_mux;

  rr_arbiter #(.N(NUM_REQ)) u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (rd_req),
    .gnt (rd_gnt)
  );

  rr_arbiter #(.N(NUM_REQ)) u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (wr_req),
    .gnt (wr_gnt)
  );

  // One-hot grants make an AND-OR mux; zero when idle.
  always_comb begin
    rd_mux = '0;
    wa_mux = '0;
    wd_mux = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rd_gnt[i]) rd_mux |= rd_addr[i*AW +: AW];
      if (wr_gnt[i]) wa_mux |= wr_addr[i*AW +: AW];
      if (wr_gnt[i]) wd_mux |= wr_data[i*DW +: DW];
    end
  end

  assign ram.ram_rd_en   = |rd_gnt;
  assign ram.ram_rd_addr = rd_mux;
  assign ram.ram_wr_en   = |wr_gnt;
  assign ram.ram_wr_addr = wa_mux;
  assign ram.ram_data_in = wd_mux;

  always_comb begin
    rd_data_d = rd_data_q;
    rd_vld_d  = rd_gnt;
    if (|rd_gnt) rd_data_d = ram.ram_data_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
      rd_vld_q  <= '0;
    end else begin
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign rd_data       = rd_data_q;
  assign rd_data_valid = rd_vld_q;

endmodule

// File: tb/tb_dp_ram_arbiter.sv
// Directed bench for dp_ram_arbiter with a behavioural
// round-robin / RAM model checked every cycle.
module tb_dp_ram_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    rd_req;
  logic [N*AW-1:0] rd_addr;
  logic [N-1:0]    rd_gnt;
  logic [DW-1:0]   rd_data;
  logic [N-1:0]    rd_data_valid;
  logic [N-1:0]    wr_req;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    wr_gnt;

  int n_cmp = 0;
  int n_bad = 0;

  dp_ram_if #(.DW(DW), .AW(AW)) ram ();

  dp_ram_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_req        (rd_req),
    .rd_addr       (rd_addr),
    .rd_gnt        (rd_gnt),
    .rd_data       (rd_data),
    .rd_data_valid (rd_data_valid),
    .wr_req        (wr_req),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_gnt        (wr_gnt),
    .ram           (ram.master)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return (a == 5) ? 8'h11 : 8'(32'h20 + a);
  endfunction

  // RAM macro: async read, write on posedge.
  logic [DW-1:0] mem [1<<AW];
  assign ram.ram_data_out = mem[ram.ram_rd_addr];
  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = init_val(i);
    forever begin
      @(posedge clk);
      if (ram.ram_wr_en) mem[ram.ram_wr_addr] <= ram.ram_data_in;
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Winner = requester with the smallest forward distance from p.
  function automatic int winner(input logic [N-1:0] r, input int p);
    int best;
    int bd;
    best = -1;
    bd   = N;
    for (int i = 0; i < N; i++) begin
      if (r[i] && ((i - p + N) % N) < bd) begin
        bd   = (i - p + N) % N;
        best = i;
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] oh(input int w);
    logic [N-1:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  initial begin
    logic [DW-1:0] m_mem [1<<AW];
    logic [DW-1:0] e_data;
    logic [N-1:0]  e_vld;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    logic          r_rst;
    int rptr, wptr, rw, ww;
    for (int i = 0; i < (1<<AW); i++) m_mem[i] = init_val(i);
    rptr = 0; wptr = 0; e_data = '0; e_vld = '0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      r_rst = rst;
      rw = r_rst ? -1 : winner(rd_req, rptr);
      ww = r_rst ? -1 : winner(wr_req, wptr);
      ra = (rw >= 0) ? rd_addr[rw*AW +: AW] : '0;
      wa = (ww >= 0) ? wr_addr[ww*AW +: AW] : '0;
      wd = (ww >= 0) ? wr_data[ww*DW +: DW] : '0;
      cmp("mdl_rd_gnt", 32'(rd_gnt), 32'(oh(rw)));
      cmp("mdl_wr_gnt", 32'(wr_gnt), 32'(oh(ww)));
      cmp("mdl_rd_en", 32'(ram.ram_rd_en), 32'(rw >= 0));
      cmp("mdl_wr_en", 32'(ram.ram_wr_en), 32'(ww >= 0));
      cmp("mdl_rd_addr", 32'(ram.ram_rd_addr), 32'(ra));
      cmp("mdl_wr_addr", 32'(ram.ram_wr_addr), 32'(wa));
      cmp("mdl_wr_data", 32'(ram.ram_data_in), 32'(wd));
      cmp("mdl_rd_data", 32'(rd_data), 32'(e_data));
      cmp("mdl_rd_vld", 32'(rd_data_valid), 32'(e_vld));
      @(posedge clk);
      if (r_rst) begin
        rptr = 0; wptr = 0; e_data = '0; e_vld = '0;
      end else begin
        e_vld = oh(rw);
        if (rw >= 0) begin
          e_data = m_mem[ra];
          rptr = (rw + 1) % N;
        end
        if (ww >= 0) begin
          m_mem[wa] = wd;
          wptr = (ww + 1) % N;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [N-1:0] seq [5];
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst = 1'b1;
    rd_req = '0; rd_addr = '0;
    wr_req = '0; wr_addr = '0; wr_data = '0;
    cyc(); cyc();
    rd_req = 4'hF; wr_req = 4'hF;
    wr_data = {4{8'hFF}};
    @(negedge clk);
    cmp("lit_rst_rd_gnt", 32'(rd_gnt), 0);
    cmp("lit_rst_wr_gnt", 32'(wr_gnt), 0);
    cmp("lit_rst_wr_en", 32'(ram.ram_wr_en), 0);
    cmp("lit_rst_rd_data", 32'(rd_data), 0);
    cmp("lit_rst_vld", 32'(rd_data_valid), 0);
    cyc();
    rst = 1'b0; wr_req = '0;
    rd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmp("lit_rr_seq", 32'(rd_gnt), 32'(seq[k]));
      cyc();
    end
    rd_req = '0; wr_req = 4'b0100;
    wr_addr = {3'd0, 3'd3, 3'd0, 3'd0};
    wr_data = {8'h00, 8'hA5, 8'h00, 8'h00};
    @(negedge clk);
    cmp("lit_nowrite_in_rst", 32'(rd_data), 32'h20);
    cmp("lit_wr_gnt2", 32'(wr_gnt), 32'b0100);
    cmp("lit_wr_addr3", 32'(ram.ram_wr_addr), 3);
    cyc();
    wr_req = '0; rd_req = 4'b0001;
    rd_addr = {3'd0, 3'd0, 3'd0, 3'd3};
    @(negedge clk);
    cmp("lit_rd_gnt0", 32'(rd_gnt), 32'b0001);
    cyc();
    rd_req = '0;
    @(negedge clk);
    cmp("lit_rd_a5", 32'(rd_data), 32'hA5);
    cmp("lit_vld_0001", 32'(rd_data_valid), 32'b0001);
    cyc();
    @(negedge clk);
    cmp("lit_hold_a5", 32'(rd_data), 32'hA5);
    cmp("lit_idle_vld", 32'(rd_data_valid), 0);
    cyc();
    wr_req = 4'b0001; rd_req = 4'b0010;
    wr_addr = {3'd0, 3'd0, 3'd0, 3'd5};
    wr_data = {8'h00, 8'h00, 8'h00, 8'h3C};
    rd_addr = {3'd0, 3'd0, 3'd5, 3'd0};
    @(negedge clk);
    cmp("lit_same_rd_gnt", 32'(rd_gnt), 32'b0010);
    cmp("lit_same_wr_gnt", 32'(wr_gnt), 32'b0001);
    cyc();
    wr_req = '0;
    @(negedge clk);
    cmp("lit_prewrite_11", 32'(rd_data), 32'h11);
    cyc();
    rd_req = '0;
    @(negedge clk);
    cmp("lit_postwrite_3c", 32'(rd_data), 32'h3C);
    cyc();
    wr_req = 4'b0010;
    wr_addr = {3'd7, 3'd0, 3'd6, 3'd0};
    wr_data = {8'h77, 8'h00, 8'h66, 8'h00};
    @(negedge clk);
    cmp("lit_wr_gnt1", 32'(wr_gnt), 32'b0010);
    cyc();
    wr_req = 4'b1010;
    wr_data = {8'h77, 8'h00, 8'h61, 8'h00};
    @(negedge clk);
    cmp("lit_ptr2_gnt3", 32'(wr_gnt), 32'b1000);
    cmp("lit_ptr2_addr7", 32'(ram.ram_wr_addr), 7);
    cyc();
    @(negedge clk);
    cmp("lit_then_gnt1", 32'(wr_gnt), 32'b0010);
    cmp("lit_then_d61", 32'(ram.ram_data_in), 32'h61);
    cyc();
    wr_req = '0; rd_req = 4'b0100;
    rd_addr = {3'd0, 3'd7, 3'd0, 3'd0};
    @(negedge clk);
    cmp("lit_rd_gnt2", 32'(rd_gnt), 32'b0100);
    cyc();
    rd_req = '0; rst = 1'b1;
    @(negedge clk);
    cmp("lit_mid_rst_en", 32'(ram.ram_rd_en), 0);
    cyc();
    rst = 1'b0; rd_req = 4'hF;
    rd_addr = {3'd3, 3'd2, 3'd1, 3'd0};
    @(negedge clk);
    cmp("lit_rst_drop_vld", 32'(rd_data_valid), 0);
    cmp("lit_rst_drop_data", 32'(rd_data), 0);
    cmp("lit_rst_ptr0", 32'(rd_gnt), 32'b0001);
    cyc();
    rd_req = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      cmp("lit_idle_rd_en", 32'(ram.ram_rd_en), 0);
      cmp("lit_idle_wr_en", 32'(ram.ram_wr_en), 0);
      cyc();
    end
    rd_req = 4'b1101; wr_req = 4'hF;
    @(negedge clk);
    cmp("lit_keep_rptr", 32'(rd_gnt), 32'b0100);
    cmp("lit_keep_wptr", 32'(wr_gnt), 32'b0001);
    cyc();
    rd_req = '0; wr_req = '0;
    cyc(); cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
